usb_tx_fifo: RTL and testbench

//  Parametrised USB serial transmitter (next generation of the low-speed sender).
//  - Accepts packet bytes over a valid/ready stream into an internal FIFO.
//  - Emits SYNC, NRZI-coded, bit-stuffed data and EOP on D+/D-.
//  - Supports low- or full-speed line polarity, programmable oversampling and packet abort.
//  - Sits between the SIE TX path and the D+/D- pad driver.

---
 rtl/usb_tx_fifo.sv | 240 ++++++++++++++++++++++++
 tb/tb_usb_tx_fifo.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_fifo.sv
// rtl/usb_tx_fifo.sv - USB serial transmitter: byte FIFO feeding SYNC, NRZI, bit stuffing and EOP on D+/D-
// Line bits advance only on the bit strobe; every state describes the bit currently driven on the line.
package usb_tx_fifo_pkg;
  // {dp, dm} with low-speed polarity: J = D- high, K = D+ high
  typedef enum logic [1:0] {D_SE0 = 2'b00, D_J = 2'b01, D_K = 2'b10} d_port_t;
endpackage

module usb_tx_fifo
  import usb_tx_fifo_pkg::*;
#(
  parameter int CLK_PER_BIT = 16,
  parameter bit LOW_SPEED   = 1'b1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       reset,
  output d_port_t    d_o,
  output logic       d_en,
  input  logic [7:0] data,
  input  logic       last,
  input  logic       valid,
  output logic       ready,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       underrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH   = (AW + 1)'(FIFO_DEPTH);
  localparam d_port_t SYM_J = LOW_SPEED ? D_J : D_K;
  localparam d_port_t SYM_K = LOW_SPEED ? D_K : D_J;

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_ABORT, S_EOP} state_t;

  // Reset asserts asynchronously and is released on a clock edge
  logic [1:0] rst_sync;
  logic       rst_n;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [8:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic        full, empty, push, pop, fsm_pop, flush_pop;
  logic [8:0]  head;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == DEPTH);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr[AW-1:0]];

  state_t      state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0]  bitcnt, bitcnt_n;
  logic [7:0]  shreg, shreg_n;
  logic        cur_last, last_n;
  logic [2:0]  ones, ones_n;
  logic        lvl, lvl_n;
  logic        se0, se0_n;
  logic        abort_pend, flush, flush_set;
  logic        strobe, eff_abort, in_tx, emit, emit_bit;

  assign ready     = rst_n && !full && (state != S_ABORT);
  assign push      = valid && ready;
  assign flush_pop = flush && !empty;
  assign pop       = fsm_pop || flush_pop;
  assign strobe    = (state != S_IDLE) && (cnt == CNT_MAX);
  assign in_tx     = (state == S_SYNC) || (state == S_DATA);
  assign eff_abort = abort_pend || abort;
  assign d_en      = (state != S_IDLE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {last, data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_comb begin
    state_n   = state;
    bitcnt_n  = bitcnt;
    shreg_n   = shreg;
    last_n    = cur_last;
    ones_n    = ones;
    lvl_n     = lvl;
    se0_n     = se0;
    fsm_pop   = 1'b0;
    flush_set = 1'b0;
    underrun  = 1'b0;
    done      = 1'b0;
    emit      = 1'b0;
    emit_bit  = 1'b0;
    case (state)
      S_IDLE: begin
        lvl_n  = 1'b1;
        se0_n  = 1'b0;
        ones_n = 3'd0;
        if (!empty && !flush) begin
          state_n  = S_SYNC;
          bitcnt_n = 3'd0;
          last_n   = 1'b0;
          emit     = 1'b1;
        end
      end
      S_SYNC: begin
        if (strobe) begin
          if (eff_abort) begin
            state_n  = S_ABORT;
            bitcnt_n = 3'd0;
          end else if (bitcnt != 3'd7) begin
            bitcnt_n = bitcnt + 3'd1;
            emit     = 1'b1;
            emit_bit = (bitcnt == 3'd6);
          end else begin
            fsm_pop  = 1'b1;
            shreg_n  = head[7:0];
            last_n   = head[8];
            bitcnt_n = 3'd0;
            state_n  = S_DATA;
            emit     = 1'b1;
            emit_bit = head[0];
          end
        end
      end
      S_DATA: begin
        // bitcnt is the index of the last data bit sent; a stuff bit leaves it unchanged
        if (strobe) begin
          if (eff_abort) begin
            state_n  = S_ABORT;
            bitcnt_n = 3'd0;
          end else if (ones == 3'd6) begin
            emit = 1'b1;
          end else if (bitcnt != 3'd7) begin
            bitcnt_n = bitcnt + 3'd1;
            shreg_n  = {1'b0, shreg[7:1]};
            emit     = 1'b1;
            emit_bit = shreg[1];
          end else if (cur_last) begin
            state_n  = S_EOP;
            bitcnt_n = 3'd0;
            se0_n    = 1'b1;
            lvl_n    = 1'b1;
            ones_n   = 3'd0;
          end else if (!empty) begin
            fsm_pop  = 1'b1;
            shreg_n  = head[7:0];
            last_n   = head[8];
            bitcnt_n = 3'd0;
            emit     = 1'b1;
            emit_bit = head[0];
          end else begin
            underrun = 1'b1;
            state_n  = S_ABORT;
            bitcnt_n = 3'd0;
          end
        end
      end
      S_ABORT: begin
        // line level simply holds: eight unstuffed ones
        if (strobe) begin
          if (bitcnt != 3'd7) begin
            bitcnt_n = bitcnt + 3'd1;
          end else begin
            flush_set = !cur_last;
            state_n   = S_EOP;
            bitcnt_n  = 3'd0;
            se0_n     = 1'b1;
            lvl_n     = 1'b1;
            ones_n    = 3'd0;
          end
        end
      end
      S_EOP: begin
        if (strobe) begin
          if (bitcnt == 3'd0) begin
            bitcnt_n = 3'd1;
          end else if (bitcnt == 3'd1) begin
            bitcnt_n = 3'd2;
            se0_n    = 1'b0;
          end else begin
            done    = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (emit) begin
      se0_n  = 1'b0;
      lvl_n  = emit_bit ? lvl : ~lvl;
      ones_n = emit_bit ? ones + 3'd1 : 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bitcnt     <= 3'd0;
      shreg      <= 8'd0;
      cur_last   <= 1'b0;
      ones       <= 3'd0;
      lvl        <= 1'b1;
      se0        <= 1'b0;
      abort_pend <= 1'b0;
      flush      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= (state == S_IDLE || strobe) ? '0 : cnt + CW'(1);
      bitcnt     <= bitcnt_n;
      shreg      <= shreg_n;
      cur_last   <= last_n;
      ones       <= ones_n;
      lvl        <= lvl_n;
      se0        <= se0_n;
      abort_pend <= in_tx && (state_n == S_SYNC || state_n == S_DATA) && eff_abort;
      // Discard the rest of an abandoned packet, up to its 'last' entry
      if (flush_set)                     flush <= 1'b1;
      else if (flush && (empty || head[8])) flush <= 1'b0;
    end
  end

  always_comb begin
    if (state == S_IDLE) d_o = SYM_J;
    else if (se0)        d_o = D_SE0;
    else                 d_o = lvl ? SYM_J : SYM_K;
  end
endmodule

// File: tb/tb_usb_tx_fifo.sv
// tb/tb_usb_tx_fifo.sv - randomized self-checking bench for usb_tx_fifo against a line-coding model
module tb_usb_tx_fifo;
  import usb_tx_fifo_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, last, valid, abort;
  logic [7:0] data;
  d_port_t    ls_d_o, fs_d_o, d_o_s;
  logic ls_d_en, ls_ready, ls_busy, ls_done, ls_under;
  logic fs_d_en, fs_ready, fs_busy, fs_done, fs_under;
  logic d_en_s, ready_s, busy_s, done_s, under_s;
  bit   sel;
  int   cpb;
  int   checks, errors;

  usb_tx_fifo dut_ls (
    .clk(clk), .reset(reset), .d_o(ls_d_o), .d_en(ls_d_en), .data(data), .last(last),
    .valid(valid), .ready(ls_ready), .abort(abort), .busy(ls_busy), .done(ls_done),
    .underrun(ls_under));

  usb_tx_fifo #(.CLK_PER_BIT(4), .LOW_SPEED(1'b0), .FIFO_DEPTH(4)) dut_fs (
    .clk(clk), .reset(reset), .d_o(fs_d_o), .d_en(fs_d_en), .data(data), .last(last),
    .valid(valid), .ready(fs_ready), .abort(abort), .busy(fs_busy), .done(fs_done),
    .underrun(fs_under));

  always_comb begin
    d_o_s   = sel ? fs_d_o   : ls_d_o;
    d_en_s  = sel ? fs_d_en  : ls_d_en;
    ready_s = sel ? fs_ready : ls_ready;
    busy_s  = sel ? fs_busy  : ls_busy;
    done_s  = sel ? fs_done  : ls_done;
    under_s = sel ? fs_under : ls_under;
  end

  logic [7:0] pkt[$];
  d_port_t    exp_q[$];
  int         exp_ur;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic d_port_t js();
    return sel ? D_K : D_J;
  endfunction

  // cut_in: -1 normal packet, -2 underrun after the bytes, >=0 abort after that many line bits
  task automatic build(input int cut_in);
    bit bits[$];
    int ones, cut;
    bit lvl, v;
    d_port_t ks;
    ks = sel ? D_J : D_K;
    bits = {};
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      v = (i == 7);
      bits.push_back(v);
      ones = v ? ones + 1 : 0;
    end
    foreach (pkt[b]) begin
      for (int i = 0; i < 8; i++) begin
        v = pkt[b][i];
        bits.push_back(v);
        ones = v ? ones + 1 : 0;
        if (ones == 6) begin
          bits.push_back(1'b0);
          ones = 0;
        end
      end
    end
    cut = (cut_in < 0) ? bits.size() : cut_in;
    exp_ur = (cut_in == -2) ? cut : -1;
    exp_q = {};
    lvl = 1'b1;
    for (int i = 0; i < cut; i++) begin
      if (!bits[i]) lvl = ~lvl;
      exp_q.push_back(lvl ? js() : ks);
    end
    if (cut_in != -1) repeat (8) exp_q.push_back(lvl ? js() : ks);
    exp_q.push_back(D_SE0);
    exp_q.push_back(D_SE0);
    exp_q.push_back(js());
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l);
    bit r;
    int n;
    data = d; last = l; valid = 1'b1;
    n = 0;
    r = 1'b0;
    while (!r && n < 3000) begin
      @(negedge clk);
      r = ready_s;
      @(posedge clk);
      #1;
      n++;
    end
    if (!r) chk("push_timeout", 32'(r), 1);
    valid = 1'b0;
  endtask

  task automatic push_pkt(input bit with_last, input bit full_chk);
    foreach (pkt[i]) begin
      push_byte(pkt[i], with_last && (i == pkt.size() - 1));
      if (full_chk && i == 3) begin
        @(negedge clk);
        chk("ready_when_full", 32'(ready_s), 0);
      end
    end
  endtask

  task automatic capture();
    int n, total, t, nbad, done_cnt, done_at, ur_cnt, ur_at, waited;
    n = exp_q.size();
    total = n * cpb;
    waited = 0;
    @(negedge clk);
    while (d_en_s !== 1'b1 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    chk("line_start", 32'(d_en_s), 1);
    if (d_en_s !== 1'b1) return;
    done_cnt = 0; done_at = -1; ur_cnt = 0; ur_at = -1; t = 0;
    for (int k = 0; k < n; k++) begin
      nbad = 0;
      for (int c = 0; c < cpb; c++) begin
        if (t > 0) @(negedge clk);
        if (d_o_s !== exp_q[k] || d_en_s !== 1'b1 || busy_s !== 1'b1) nbad++;
        if (done_s === 1'b1) begin done_cnt++; done_at = t; end
        if (under_s === 1'b1) begin ur_cnt++; ur_at = t; end
        t++;
      end
      chk($sformatf("bit%0d_bad_cycles", k), 32'(nbad), 0);
    end
    @(negedge clk);
    chk("d_en_after_eop", 32'(d_en_s), 0);
    chk("busy_after_eop", 32'(busy_s), 0);
    chk("done_count", 32'(done_cnt), 1);
    chk("done_cycle", 32'(done_at), 32'(total - 1));
    chk("underrun_count", 32'(ur_cnt), (exp_ur >= 0) ? 1 : 0);
    chk("underrun_cycle", 32'(ur_at), (exp_ur >= 0) ? 32'(exp_ur * cpb - 1) : 32'hFFFF_FFFF);
  endtask

  task automatic pulse_abort(input int k);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (d_en_s !== 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (k * cpb + cpb / 2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
  endtask

  task automatic run_pkt(input int mode, input int abort_k, input bit full_chk);
    build((abort_k >= 0) ? abort_k + 1 : mode);
    fork
      push_pkt(mode != -2, full_chk);
      capture();
      begin
        if (abort_k >= 0) pulse_abort(abort_k);
      end
    join
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid = 1'b0; abort = 1'b0; reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready_s), 1);
    chk("rst_d_en", 32'(d_en_s), 0);
    chk("rst_busy", 32'(busy_s), 0);
    chk("rst_done", 32'(done_s), 0);
    chk("rst_underrun", 32'(under_s), 0);
    chk("rst_d_o", 32'(d_o_s), 32'(js()));
    @(posedge clk);
    #1;
  endtask

  task automatic stay_idle(input string tag);
    int hi;
    hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (d_en_s !== 1'b0) hi++;
    end
    chk({tag, "_quiet"}, 32'(hi), 0);
    chk({tag, "_ready"}, 32'(ready_s), 1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rnd_byte();
    return ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
  endfunction

  initial begin
    #4_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, k;
    checks = 0; errors = 0;
    reset = 1'b0; data = 8'd0; last = 1'b0; valid = 1'b0; abort = 1'b0;
    sel = 1'b0; cpb = 16;
    do_reset();

    pkt = {8'h00};
    run_pkt(-1, -1, 1'b0);
    pkt = {8'hFF};
    run_pkt(-1, -1, 1'b0);
    pkt = {8'h3C};
    run_pkt(-2, -1, 1'b0);
    stay_idle("after_underrun");

    pkt = {};
    for (int i = 0; i < 6; i++) pkt.push_back(rnd_byte());
    run_pkt(-1, -1, 1'b1);

    pkt = {rnd_byte(), rnd_byte(), rnd_byte()};
    run_pkt(-1, 20, 1'b0);
    stay_idle("after_flush");
    pkt = {8'hA5, 8'h7E};
    run_pkt(-1, -1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 5);
      pkt = {};
      for (int i = 0; i < len; i++) pkt.push_back(rnd_byte());
      if (len >= 2 && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(9, 8 + 8 * len - 1);
        run_pkt(-1, k, 1'b0);
      end else begin
        run_pkt(-1, -1, 1'b0);
      end
    end

    pkt = {rnd_byte()};
    push_pkt(1'b1, 1'b0);
    repeat (10 * cpb) @(posedge clk);
    #1;
    chk("busy_mid_data", 32'(busy_s), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_d_en", 32'(d_en_s), 0);
    chk("mid_rst_d_o", 32'(d_o_s), 32'(js()));
    chk("mid_rst_busy", 32'(busy_s), 0);
    do_reset();
    stay_idle("after_mid_reset");

    sel = 1'b1; cpb = 4;
    do_reset();
    pkt = {8'h00};
    run_pkt(-1, -1, 1'b0);
    pkt = {rnd_byte(), 8'hFF, rnd_byte()};
    run_pkt(-1, -1, 1'b0);
    pkt = {8'h3C};
    run_pkt(-2, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
